// File: rtl/counter_rr_sched_if.sv
// Requester-side bus of counter_rr_sched: level requests in, one-hot grant and
// one-cycle response back. The scheduler takes the slave modport.
interface counter_rr_sched_if #(
  parameter int W    = 8,
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] req_op;
  logic [W*NREQ-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_count;
  logic              rsp_rollover;
  logic              rsp_err;

  modport master (
    output req, req_op, req_data,
    input  gnt, rsp_valid, rsp_id, rsp_count, rsp_rollover, rsp_err
  );

  modport slave (
    input  req, req_op, req_data,
    output gnt, rsp_valid, rsp_id, rsp_count, rsp_rollover, rsp_err
  );
endinterface

// File: rtl/counter_rr_sched.sv
// Round-robin scheduler sharing one external up/down/load counter among NREQ requesters.
// Define COUNTER_RR_SCHED_SAT_EN to reject up-at-max / down-at-zero instead of wrapping.
module counter_rr_sched #(
  parameter int W    = 8,
  parameter int NREQ = 4
) (
  input  logic                     clk,
  input  logic                     srst,
  counter_rr_sched_if.slave        req_bus,
  output logic                     cnt_load,
  output logic                     cnt_up,
  output logic                     cnt_down,
  output logic [W-1:0]             cnt_data,
  input  logic [W-1:0]             cnt_count,
  input  logic                     cnt_rollover,
  output logic                     busy
);
  localparam int IDW = $clog2(NREQ);

  localparam logic [1:0] OP_UP   = 2'b00;
  localparam logic [1:0] OP_DOWN = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t          state_q, state_nxt;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  id_q;
  logic            win_found;
  logic [IDW-1:0]  win_id;
  logic [1:0]      win_op;
  logic [W-1:0]    win_data;
  logic            reject;
  logic [NREQ-1:0] gnt_nxt;
  logic            load_nxt, up_nxt, down_nxt;

  // First requester at or above the pointer, wrapping modulo NREQ.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    win_op    = OP_READ;
    win_data  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!win_found && req_bus.req[idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
        win_op    = req_bus.req_op[2*idx +: 2];
        win_data  = req_bus.req_data[W*idx +: W];
      end
    end
  end

`ifdef COUNTER_RR_SCHED_SAT_EN
  logic err_q;

  // Strobes are registered at the IDLE->ISSUE edge, so the limit check uses the count seen in IDLE.
  assign reject = ((win_op == OP_UP)   && (cnt_count == {W{1'b1}})) ||
                  ((win_op == OP_DOWN) && (cnt_count == '0));

  always_ff @(posedge clk) begin
    if (srst) begin
      err_q           <= 1'b0;
      req_bus.rsp_err <= 1'b0;
    end else begin
      if (state_q == IDLE && win_found) err_q <= reject;
      req_bus.rsp_err <= (state_q == WAIT) && err_q;
    end
  end
`else
  assign reject          = 1'b0;
  assign req_bus.rsp_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state_q;
    gnt_nxt   = '0;
    load_nxt  = 1'b0;
    up_nxt    = 1'b0;
    down_nxt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_nxt = ISSUE;
          gnt_nxt   = NREQ'(1) << win_id;
          if (!reject) begin
            load_nxt = (win_op == OP_LOAD);
            up_nxt   = (win_op == OP_UP);
            down_nxt = (win_op == OP_DOWN);
          end
        end
      end
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q              <= IDLE;
      ptr_q                <= '0;
      id_q                 <= '0;
      req_bus.gnt          <= '0;
      cnt_load             <= 1'b0;
      cnt_up               <= 1'b0;
      cnt_down             <= 1'b0;
      cnt_data             <= '0;
      req_bus.rsp_valid    <= 1'b0;
      req_bus.rsp_id       <= '0;
      req_bus.rsp_count    <= '0;
      req_bus.rsp_rollover <= 1'b0;
      busy                 <= 1'b0;
    end else begin
      state_q           <= state_nxt;
      req_bus.gnt       <= gnt_nxt;
      cnt_load          <= load_nxt;
      cnt_up            <= up_nxt;
      cnt_down          <= down_nxt;
      busy              <= (state_nxt != IDLE);
      req_bus.rsp_valid <= (state_q == WAIT);
      if (state_q == IDLE && win_found) begin
        id_q <= win_id;
        if (win_op == OP_LOAD) cnt_data <= win_data;
      end
      if (state_q == ISSUE) ptr_q <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
      // The counter settled at the ISSUE->WAIT edge; capture it for the response.
      if (state_q == WAIT) begin
        req_bus.rsp_count    <= cnt_count;
        req_bus.rsp_rollover <= cnt_rollover;
        req_bus.rsp_id       <= id_q;
      end
    end
  end
endmodule

// File: tb/tb_counter_rr_sched.sv
// Self-checking bench for counter_rr_sched: external counter model plus a
// round-robin/arithmetic reference model for randomized traffic.
module tb_counter_rr_sched;
  localparam int W    = 8;
  localparam int NREQ = 4;
`ifdef COUNTER_RR_SCHED_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam logic [1:0] OP_UP   = 2'b00;
  localparam logic [1:0] OP_DOWN = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  logic       clk = 1'b0;
  logic       srst;
  logic       cnt_load, cnt_up, cnt_down, cnt_rollover, busy;
  logic [7:0] cnt_data;
  logic [7:0] cnt_count;
  logic       set_en;
  logic [7:0] set_val;
  int         n_tests = 0;
  int         n_fail  = 0;

  typedef struct packed {
    logic [3:0] gnt;
    int         gnt_lat;
    logic       load;
    logic       up;
    logic       down;
    logic [7:0] data;
    int         nstrobe;
    logic       both;
    int         rsp_lat;
    logic [1:0] id;
    logic [7:0] count;
    logic       roll;
    logic       err;
    logic       to;
  } obs_t;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] count;
    logic       roll;
    logic       err;
  } rsp_t;

  counter_rr_sched_if #(.W(W), .NREQ(NREQ)) rq();

  counter_rr_sched #(.W(W), .NREQ(NREQ)) dut (
    .clk          (clk),
    .srst         (srst),
    .req_bus      (rq),
    .cnt_load     (cnt_load),
    .cnt_up       (cnt_up),
    .cnt_down     (cnt_down),
    .cnt_data     (cnt_data),
    .cnt_count    (cnt_count),
    .cnt_rollover (cnt_rollover),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // The shared counter the scheduler drives; set_en lets the bench preload it.
  always @(posedge clk) begin
    if (set_en)        cnt_count <= set_val;
    else if (cnt_load) cnt_count <= cnt_data;
    else if (cnt_up)   cnt_count <= cnt_count + 8'd1;
    else if (cnt_down) cnt_count <= cnt_count - 8'd1;
  end
  assign cnt_rollover = &cnt_count;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_count(input logic [7:0] v);
    set_en  = 1'b1;
    set_val = v;
    tick();
    set_en  = 1'b0;
  endtask

  // Round-robin rule: nearest set bit at or after p, wrapping.
  function automatic int pick(input logic [3:0] m, input int p);
    int r;
    r = -1;
    for (int k = NREQ - 1; k >= 0; k--)
      if (m[(p + k) % NREQ] === 1'b1) r = (p + k) % NREQ;
    return r;
  endfunction

  task automatic drive_one(input int id, input logic [1:0] op, input logic [7:0] d);
    rq.req             = '0;
    rq.req[id]         = 1'b1;
    rq.req_op[2*id +: 2] = op;
    rq.req_data[8*id +: 8] = d;
  endtask

  task automatic run_op(input int id, input logic [1:0] op, input logic [7:0] d, output obs_t o);
    int t;
    o = '0;
    t = 0;
    drive_one(id, op, d);
    while (t < 8 && rq.gnt == '0) begin
      tick();
      t++;
      o.nstrobe += int'(cnt_load) + int'(cnt_up) + int'(cnt_down);
      o.both    |= cnt_up & cnt_down;
    end
    if (rq.gnt == '0) o.to = 1'b1;
    o.gnt     = rq.gnt;
    o.gnt_lat = t;
    o.load    = cnt_load;
    o.up      = cnt_up;
    o.down    = cnt_down;
    o.data    = cnt_data;
    rq.req    = '0;
    while (t < 12 && !rq.rsp_valid) begin
      tick();
      t++;
      o.nstrobe += int'(cnt_load) + int'(cnt_up) + int'(cnt_down);
      o.both    |= cnt_up & cnt_down;
    end
    if (!rq.rsp_valid) o.to = 1'b1;
    o.rsp_lat = t;
    o.id      = rq.rsp_id;
    o.count   = rq.rsp_count;
    o.roll    = rq.rsp_rollover;
    o.err     = rq.rsp_err;
  endtask

  task automatic test_reset();
    srst        = 1'b1;
    rq.req      = 4'hF;
    rq.req_op   = 8'hFF;
    rq.req_data = '0;
    set_en      = 1'b1;
    set_val     = 8'h10;
    repeat (3) tick();
    set_en = 1'b0;
    n_tests++; if (rq.gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", rq.gnt); end
    n_tests++; if ({cnt_load, cnt_up, cnt_down} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes: got %b expected 000", {cnt_load, cnt_up, cnt_down}); end
    n_tests++; if ({rq.rsp_valid, rq.rsp_err, rq.rsp_rollover, busy} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {rq.rsp_valid, rq.rsp_err, rq.rsp_rollover, busy}); end
    n_tests++; if ({cnt_data, rq.rsp_count, rq.rsp_id} !== 18'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", {cnt_data, rq.rsp_count, rq.rsp_id}); end
    srst = 1'b0;
    tick();
    n_tests++; if (rq.gnt !== 4'b0001) begin n_fail++; $display("FAIL reset_first_gnt: got %b expected 0001", rq.gnt); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", busy); end
    repeat (2) tick();
    n_tests++; if ({rq.rsp_valid, rq.rsp_id, rq.rsp_count} !== {1'b1, 2'd0, 8'h10}) begin n_fail++; $display("FAIL reset_first_rsp: got %b/%0d/%h expected 1/0/10", rq.rsp_valid, rq.rsp_id, rq.rsp_count); end
    tick();
    n_tests++; if (rq.gnt !== 4'b0010) begin n_fail++; $display("FAIL reset_ptr_adv: got %b expected 0010", rq.gnt); end
    rq.req = '0;
    repeat (3) tick();
  endtask

  task automatic test_load_read();
    obs_t o;
    run_op(2, OP_LOAD, 8'hA5, o);
    n_tests++; if (o.to !== 1'b0) begin n_fail++; $display("FAIL load_timeout: got %b expected 0", o.to); end
    n_tests++; if (o.gnt !== 4'b0100 || o.gnt_lat !== 1) begin n_fail++; $display("FAIL load_gnt: got %b lat %0d expected 0100 lat 1", o.gnt, o.gnt_lat); end
    n_tests++; if ({o.load, o.up, o.down} !== 3'b100 || o.data !== 8'hA5) begin n_fail++; $display("FAIL load_strobe: got %b data %h expected 100 data a5", {o.load, o.up, o.down}, o.data); end
    n_tests++; if (o.nstrobe !== 1 || o.both !== 1'b0) begin n_fail++; $display("FAIL load_nstrobe: got %0d expected 1", o.nstrobe); end
    n_tests++; if (o.rsp_lat !== 3) begin n_fail++; $display("FAIL load_rsp_lat: got %0d expected 3", o.rsp_lat); end
    n_tests++; if ({o.id, o.count, o.roll, o.err} !== {2'd2, 8'hA5, 1'b0, 1'b0}) begin n_fail++; $display("FAIL load_rsp: got %0d/%h/%b/%b expected 2/a5/0/0", o.id, o.count, o.roll, o.err); end
    run_op(2, OP_READ, 8'h00, o);
    n_tests++; if (o.to !== 1'b0 || o.gnt !== 4'b0100) begin n_fail++; $display("FAIL read_gnt: got %b to %b expected 0100", o.gnt, o.to); end
    n_tests++; if (o.nstrobe !== 0) begin n_fail++; $display("FAIL read_nstrobe: got %0d expected 0", o.nstrobe); end
    n_tests++; if ({o.id, o.count} !== {2'd2, 8'hA5}) begin n_fail++; $display("FAIL read_rsp: got %0d/%h expected 2/a5", o.id, o.count); end
  endtask

  task automatic test_all_up();
    int   mptr, mcnt, last_g, ngr, nrsp, e;
    rsp_t q[$];
    rsp_t r;
    set_count(8'h00);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    mptr = 0; mcnt = 0; last_g = 0; ngr = 0; nrsp = 0;
    rq.req_op = '0;
    rq.req    = 4'hF;
    for (int t = 1; t <= 60 && nrsp < 12; t++) begin
      tick();
      n_tests++; if (cnt_up && cnt_down) begin n_fail++; $display("FAIL allup_both: got up&down expected exclusive"); end
      if (rq.gnt != '0) begin
        e = pick(4'hF, mptr);
        n_tests++; if (rq.gnt !== 4'(1 << e)) begin n_fail++; $display("FAIL allup_order: got %b expected %b", rq.gnt, 4'(1 << e)); end
        if (ngr > 0) begin
          n_tests++; if (t - last_g !== 3) begin n_fail++; $display("FAIL allup_spacing: got %0d expected 3", t - last_g); end
        end
        last_g = t;
        mptr   = (e + 1) % NREQ;
        mcnt   = (mcnt + 1) % 256;
        q.push_back('{id: 2'(e), count: 8'(mcnt), roll: (mcnt == 255), err: 1'b0});
        ngr++;
        if (ngr == 12) rq.req = '0;
      end
      if (rq.rsp_valid) begin
        nrsp++;
        n_tests++;
        if (q.size() == 0) begin n_fail++; $display("FAIL allup_rsp: got unexpected rsp id %0d expected none", rq.rsp_id); end
        else begin
          r = q.pop_front();
          if ({rq.rsp_id, rq.rsp_count} !== {r.id, r.count}) begin n_fail++; $display("FAIL allup_rsp: got %0d/%h expected %0d/%h", rq.rsp_id, rq.rsp_count, r.id, r.count); end
        end
      end
    end
    n_tests++; if (nrsp !== 12) begin n_fail++; $display("FAIL allup_count: got %0d responses expected 12", nrsp); end
    rq.req = '0;
    repeat (3) tick();
  endtask

  task automatic test_wrap_up();
    obs_t o;
    set_count(8'hFF);
    run_op(1, OP_UP, 8'h00, o);
    n_tests++; if (o.to !== 1'b0 || o.gnt !== 4'b0010) begin n_fail++; $display("FAIL wrapup_gnt: got %b to %b expected 0010", o.gnt, o.to); end
    n_tests++; if (o.nstrobe !== (SAT ? 0 : 1) || o.up !== !SAT) begin n_fail++; $display("FAIL wrapup_strobe: got %0d up %b expected %0d", o.nstrobe, o.up, SAT ? 0 : 1); end
    n_tests++; if ({o.count, o.roll, o.err} !== (SAT ? {8'hFF, 1'b1, 1'b1} : {8'h00, 1'b0, 1'b0})) begin n_fail++; $display("FAIL wrapup_rsp: got %h/%b/%b sat %b", o.count, o.roll, o.err, SAT); end
  endtask

  task automatic test_wrap_down();
    obs_t o;
    set_count(8'h00);
    run_op(3, OP_DOWN, 8'h00, o);
    n_tests++; if (o.to !== 1'b0 || o.gnt !== 4'b1000) begin n_fail++; $display("FAIL wrapdn_gnt: got %b to %b expected 1000", o.gnt, o.to); end
    n_tests++; if (o.nstrobe !== (SAT ? 0 : 1) || o.down !== !SAT) begin n_fail++; $display("FAIL wrapdn_strobe: got %0d down %b expected %0d", o.nstrobe, o.down, SAT ? 0 : 1); end
    n_tests++; if ({o.count, o.roll, o.err} !== (SAT ? {8'h00, 1'b0, 1'b1} : {8'hFF, 1'b1, 1'b0})) begin n_fail++; $display("FAIL wrapdn_rsp: got %h/%b/%b sat %b", o.count, o.roll, o.err, SAT); end
  endtask

  task automatic test_reset_mid();
    drive_one(2, OP_LOAD, 8'h5A);
    tick();
    n_tests++; if (rq.gnt !== 4'b0100 || cnt_load !== 1'b1) begin n_fail++; $display("FAIL rstmid_issue: got %b load %b expected 0100 1", rq.gnt, cnt_load); end
    rq.req = '0;
    tick();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_wait_busy: got %b expected 1", busy); end
    srst = 1'b1;
    tick();
    srst = 1'b0;
    n_tests++; if ({rq.gnt, cnt_load, cnt_up, cnt_down, rq.rsp_valid, rq.rsp_err, rq.rsp_rollover, busy} !== 11'b0) begin n_fail++; $display("FAIL rstmid_ctrl: got %b expected 0", {rq.gnt, cnt_load, cnt_up, cnt_down, rq.rsp_valid, rq.rsp_err, rq.rsp_rollover, busy}); end
    n_tests++; if ({cnt_data, rq.rsp_count, rq.rsp_id} !== 18'h0) begin n_fail++; $display("FAIL rstmid_data: got %h expected 0", {cnt_data, rq.rsp_count, rq.rsp_id}); end
    rq.req_op = 8'hFF;
    rq.req    = 4'hF;
    tick();
    n_tests++; if (rq.gnt !== 4'b0001 || rq.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_ptr: got %b rsp %b expected 0001 0", rq.gnt, rq.rsp_valid); end
    rq.req = '0;
    repeat (3) tick();
  endtask

  task automatic test_random();
    localparam int N = 150;
    int         mptr, mcnt, ngr, nrsp, e;
    logic [3:0] pend, prev;
    logic [1:0] ops[NREQ];
    logic [7:0] dats[NREQ];
    logic       el, eu, ed, er;
    rsp_t       q[$];
    rsp_t       r;
    srst = 1'b1;
    tick();
    srst = 1'b0;
    mcnt = int'($urandom_range(255, 0));
    set_count(8'(mcnt));
    mptr = 0; ngr = 0; nrsp = 0;
    pend = 4'(1 + $urandom_range(14, 0));
    for (int i = 0; i < NREQ; i++) begin
      ops[i]  = 2'($urandom_range(3, 0));
      dats[i] = 8'($urandom);
      rq.req_op[2*i +: 2]   = ops[i];
      rq.req_data[8*i +: 8] = dats[i];
    end
    rq.req = pend;
    for (int t = 0; t < 2000 && nrsp < N; t++) begin
      prev = rq.req;
      tick();
      n_tests++; if (cnt_up && cnt_down) begin n_fail++; $display("FAIL rand_both: got up&down expected exclusive"); end
      if (rq.gnt != '0) begin
        e = pick(prev, mptr);
        n_tests++; if (e < 0 || rq.gnt !== 4'(1 << e)) begin n_fail++; $display("FAIL rand_gnt: got %b expected winner %0d of %b", rq.gnt, e, prev); end
        if (e >= 0) begin
          el = 1'b0; eu = 1'b0; ed = 1'b0; er = 1'b0;
          case (ops[e])
            OP_UP:   if (SAT && mcnt == 255) er = 1'b1; else begin mcnt = (mcnt + 1) % 256; eu = 1'b1; end
            OP_DOWN: if (SAT && mcnt == 0) er = 1'b1; else begin mcnt = (mcnt + 255) % 256; ed = 1'b1; end
            OP_LOAD: begin mcnt = int'(dats[e]); el = 1'b1; end
            default: ;
          endcase
          n_tests++; if ({cnt_load, cnt_up, cnt_down} !== {el, eu, ed} || (el && cnt_data !== dats[e])) begin n_fail++; $display("FAIL rand_strobe: got %b data %h expected %b data %h", {cnt_load, cnt_up, cnt_down}, cnt_data, {el, eu, ed}, dats[e]); end
          q.push_back('{id: 2'(e), count: 8'(mcnt), roll: (mcnt == 255), err: er});
          mptr    = (e + 1) % NREQ;
          pend[e] = 1'b0;
          ngr++;
        end
      end
      if (rq.rsp_valid) begin
        nrsp++;
        n_tests++;
        if (q.size() == 0) begin n_fail++; $display("FAIL rand_rsp: got unexpected rsp id %0d expected none", rq.rsp_id); end
        else begin
          r = q.pop_front();
          if ({rq.rsp_id, rq.rsp_count, rq.rsp_rollover, rq.rsp_err} !== {r.id, r.count, r.roll, r.err}) begin n_fail++; $display("FAIL rand_rsp: got %0d/%h/%b/%b expected %0d/%h/%b/%b", rq.rsp_id, rq.rsp_count, rq.rsp_rollover, rq.rsp_err, r.id, r.count, r.roll, r.err); end
        end
      end
      // New requests appear only after a grant or when everyone is idle, and are held until granted.
      if (rq.gnt != '0 || pend == '0) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!pend[i] && (ngr + $countones(pend)) < N && ($urandom_range(1, 0) == 1 || pend == '0)) begin
            pend[i] = 1'b1;
            ops[i]  = 2'($urandom_range(3, 0));
            dats[i] = 8'($urandom);
            rq.req_op[2*i +: 2]   = ops[i];
            rq.req_data[8*i +: 8] = dats[i];
          end
        end
        rq.req = pend;
      end
    end
    n_tests++; if (nrsp !== N) begin n_fail++; $display("FAIL rand_count: got %0d responses expected %0d", nrsp, N); end
    rq.req = '0;
    repeat (3) tick();
  endtask

  initial begin
    srst   = 1'b1;
    set_en = 1'b0;
    set_val = '0;
    rq.req = '0;
    rq.req_op = '0;
    rq.req_data = '0;
    test_reset();
    test_load_read();
    test_all_up();
    test_wrap_up();
    test_wrap_down();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
